// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key map and row/column decode helpers for the keypad scanner.
package keypad_pkg;

    typedef enum logic {SCAN, HOLD} scan_state_t;

    localparam logic [3:0] COL_INIT = 4'b1110;

    localparam logic [3:0] KEYMAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic [1:0] row_index(logic [3:0] rs);
        return !rs[0] ? 2'd0 : !rs[1] ? 2'd1 : !rs[2] ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [1:0] col_index(logic [3:0] col_n);
        return row_index(col_n);
    endfunction

    function automatic logic [2:0] onehot_cnt(logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the locked-key outputs to the debouncer.
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_pressed;
    modport master (input row_n, output col_n, output key_code, output key_pressed);
    modport slave (output row_n, input col_n, input key_code, input key_pressed);
endinterface

// File: rtl/row_synchronizer.sv
// row_synchronizer: STAGES-deep flop chain bringing the asynchronous rows into the clk domain.
module row_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] sr [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) sr[i] <= 4'hF;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[STAGES-1];
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scanner that locks the first pressed key and reports its hex code.
// KEYPAD_MULTIKEY_REJECT_EN: ignore scan ticks that see two or more rows low.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV    = 1200,
    parameter int SYNC_STAGES = 2
) (
    input logic              clk,
    input logic              reset,
    keypad_scanner_if.master kp
);
    localparam int CW = $clog2(SCAN_DIV);

    scan_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    col, col_nx, code, code_nx, rs;
    logic          pressed, pressed_nx, tick, hit;

    row_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.row_n),
        .q     (rs)
    );

    assign tick = cnt == CW'(SCAN_DIV - 1);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    assign hit = onehot_cnt(~rs) == 3'd1;
`else
    assign hit = rs != 4'hF;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SCAN;
            cnt     <= '0;
            col     <= COL_INIT;
            code    <= 4'h0;
            pressed <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            col     <= col_nx;
            code    <= code_nx;
            pressed <= pressed_nx;
        end
    end

    // State only changes on tick, so wrapping on tick also clears the dwell on every transition.
    always_comb begin
        state_nx   = state;
        col_nx     = col;
        code_nx    = code;
        pressed_nx = pressed;
        cnt_nx     = tick ? '0 : cnt + 1'b1;
        case (state)
            SCAN: if (tick) begin
                if (hit) begin
                    state_nx   = HOLD;
                    code_nx    = KEYMAP[row_index(rs)][col_index(col)];
                    pressed_nx = 1'b1;
                end else begin
                    col_nx = {col[2:0], col[3]};
                end
            end
            HOLD: if (tick && rs == 4'hF) begin
                state_nx   = SCAN;
                pressed_nx = 1'b0;
                col_nx     = {col[2:0], col[3]};
            end
            default: begin
                state_nx   = SCAN;
                col_nx     = COL_INIT;
                pressed_nx = 1'b0;
                cnt_nx     = '0;
            end
        endcase
    end

    assign kp.col_n       = col;
    assign kp.key_code    = code;
    assign kp.key_pressed = pressed;
endmodule
